// File: rtl/fpa_stream_acc.sv
// fpa_stream_acc
//   Streams IEEE-754 single-precision values into a running sum, one element
//   per cycle. The float addition itself is done by an external combinational
//   `fpa` adder that the parent instantiates. This block drives the adder's
//   operands and captures its packed result.
//
//   Handshake rule (both ports): a transfer happens on a rising clk edge where
//   valid and ready are both 1. The source holds data stable while valid=1 and
//   ready=0. This block never makes in_ready depend on in_valid.
//
// Parameters
//   CNT_W       width of the element counter; saturates at all-ones
//
// Optional build macro
//   FPA_STREAM_ACC_NAN_STICKY_EN  a NaN seen anywhere in a stream forces the
//                                 canonical NaN 32'h7FC0_0000 as the result
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      input element handshake
//   in_data, in_last       element value, end-of-sum marker
//   fpa_a, fpa_b           operands to fpa (accumulator, in_data)
//   fpa_sign/exp/mantis    sum returned by fpa
//   out_valid/out_ready    result handshake
//   out_data, out_count    packed sum and number of elements (saturating)
//   dbg_state              current FSM state (IDLE=0, ACC=1, HOLD=2)
module fpa_stream_acc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      fpa_a,
  output logic [31:0]      fpa_b,
  input  logic             fpa_sign,
  input  logic [7:0]       fpa_exp,
  input  logic [22:0]      fpa_mantis,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             accept;
  logic [31:0]      fpa_res;
  logic [31:0]      acc_next;
  logic [CNT_W-1:0] count_inc;

  assign fpa_res   = {fpa_sign, fpa_exp, fpa_mantis};
  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid & in_ready;
  assign fpa_a     = acc_q;
  assign fpa_b     = in_data;
  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;

`ifdef FPA_STREAM_ACC_NAN_STICKY_EN
  logic nan_seen_q, nan_seen_d;
  logic nan_next;

  // Once any NaN enters the stream the adder's output is no longer trusted;
  // the accumulator is pinned to the canonical quiet NaN.
  assign nan_next = nan_seen_q
                  | ((in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0))
                  | ((fpa_res[30:23] == 8'hFF) && (fpa_res[22:0] != 23'd0));
  assign acc_next = nan_next ? CANON_NAN : fpa_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nan_seen_q <= 1'b0;
    else        nan_seen_q <= nan_seen_d;
  end
`else
  assign acc_next = fpa_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 32'h0000_0000;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
`ifdef FPA_STREAM_ACC_NAN_STICKY_EN
    nan_seen_d  = nan_seen_q;
`endif

    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d   = acc_next;
          count_d = count_inc;
`ifdef FPA_STREAM_ACC_NAN_STICKY_EN
          nan_seen_d = nan_next;
`endif
          if (in_last) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_data_d  = acc_next;
            out_count_d = count_inc;
          end else begin
            state_d = ACC;
          end
        end
      end
      HOLD: begin
        // Inputs are ignored here; the accumulator is cleared only when the
        // result leaves, so in_ready rises one cycle after the handshake.
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          acc_d       = 32'h0000_0000;
          count_d     = '0;
`ifdef FPA_STREAM_ACC_NAN_STICKY_EN
          nan_seen_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fpa_stream_acc.sv
// Directed testbench for fpa_stream_acc. A small behavioural float adder
// stands in for the parent-level `fpa`: NaN operands propagate with the quiet
// bit set, and other sums go through double precision (exact for the values
// used here).
module tb_fpa_stream_acc;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic [31:0]      fpa_a;
  logic [31:0]      fpa_b;
  logic             fpa_sign;
  logic [7:0]       fpa_exp;
  logic [22:0]      fpa_mantis;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fpa_stream_acc #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .fpa_a      (fpa_a),
    .fpa_b      (fpa_b),
    .fpa_sign   (fpa_sign),
    .fpa_exp    (fpa_exp),
    .fpa_mantis (fpa_mantis),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- fpa model ----------------
  function automatic real sp2r(input logic [31:0] a);
    logic [63:0] d;
    if (a[30:23] == 8'd0) return 0.0;
    d = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a | 32'h0040_0000;
    if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b | 32'h0040_0000;
    return r2sp(sp2r(a) + sp2r(b));
  endfunction

  assign {fpa_sign, fpa_exp, fpa_mantis} = fp_add(fpa_a, fpa_b);

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] nan_exp;

  initial begin
`ifdef FPA_STREAM_ACC_NAN_STICKY_EN
    nan_exp = 32'h7FC0_0000;
`else
    nan_exp = 32'h7FC0_0001;
`endif
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_acc", fpa_a, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1.0 + 2.0 = 3.0
    drive(1'b1, 32'h3F80_0000, 1'b0);
    tick();
    chk("s1_acc_after_first", fpa_a, 32'h3F80_0000);
    chk("s1_state_acc", 32'(dbg_state), 32'd1);
    drive(1'b1, 32'h4000_0000, 1'b1);
    chk("s1_in_ready", 32'(in_ready), 32'd1);
    chk("s1_no_early_valid", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("s1_out_valid", 32'(out_valid), 32'd1);
    chk("s1_out_data", out_data, 32'h4040_0000);
    chk("s1_out_count", 32'(out_count), 32'd2);
    chk("s1_in_ready_hold", 32'(in_ready), 32'd0);
    tick();
    chk("s1_valid_cleared", 32'(out_valid), 32'd0);
    chk("s1_in_ready_back", 32'(in_ready), 32'd1);
    chk("s1_acc_cleared", fpa_a, 32'h0);

    // single element -10.0
    drive(1'b1, 32'hC120_0000, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("s2_out_data", out_data, 32'hC120_0000);
    chk("s2_out_count", 32'(out_count), 32'd1);
    tick();

    // backpressure in HOLD with a pending input
    out_ready = 1'b0;
    drive(1'b1, 32'h3F80_0000, 1'b1);
    tick();
    chk("s3_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("s3_hold_in_ready", 32'(in_ready), 32'd0);
      chk("s3_hold_data", out_data, 32'h3F80_0000);
      chk("s3_hold_count", 32'(out_count), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("s3_handshake_valid", 32'(out_valid), 32'd0);
    chk("s3_idle_in_ready", 32'(in_ready), 32'd1);
    chk("s3_idle_acc", fpa_a, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("s3_second_valid", 32'(out_valid), 32'd1);
    chk("s3_second_data", out_data, 32'h3F80_0000);
    chk("s3_second_count", 32'(out_count), 32'd1);
    tick();

    // twenty back-to-back 1.0, counter saturates at 4'hF
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h3F80_0000, (i == 19));
      chk("s4_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    chk("s4_out_valid", 32'(out_valid), 32'd1);
    chk("s4_out_data", out_data, 32'h41A0_0000);
    chk("s4_out_count", 32'(out_count), 32'hF);
    tick();

    // async reset mid-stream
    drive(1'b1, 32'h4040_0000, 1'b0);
    tick();
    drive(1'b1, 32'h3F80_0000, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("s5_acc_before_rst", fpa_a, 32'h4080_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", 32'(out_valid), 32'd0);
    chk("s5_rst_acc", fpa_a, 32'h0);
    chk("s5_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b1, 32'h3F80_0000, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("s5_out_data", out_data, 32'h3F80_0000);
    chk("s5_out_count", 32'(out_count), 32'd1);
    tick();

    // NaN in the middle of a stream
    drive(1'b1, 32'h3F80_0000, 1'b0);
    tick();
    drive(1'b1, 32'h7FC0_0001, 1'b0);
    tick();
    drive(1'b1, 32'h4000_0000, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("s6_out_valid", 32'(out_valid), 32'd1);
    chk("s6_out_data", out_data, nan_exp);
    chk("s6_out_count", 32'(out_count), 32'd3);
    tick();
    chk("s6_acc_cleared", fpa_a, 32'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpa_stream_acc.md
Name: fpa_stream_acc

Overview:
- Sequential accumulation stage wrapped around the combinational float adder `fpa`; it feeds the adder's operands and consumes its {sign, exp, mantis} result.
- Accepts a stream of IEEE-754 single-precision values over a valid/ready handshake and accumulates them one per cycle.
- On the element flagged last, presents the packed sum and element count on a valid/ready output port.
- `fpa` is instantiated at the parent level; this block only drives its operands and captures its result.

Parameters:
- CNT_W, 16, width of the accepted-element counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element this cycle.
- in_data  in  32  IEEE-754 single {sign, exp[7:0], mantis[22:0]}.
- in_last  in  1  qualifies in_data as the final element of the current sum.
- fpa_a  out  32  to fpa number_A; always equals acc register.
- fpa_b  out  32  to fpa number_B; always equals in_data (combinational pass-through).
- fpa_sign  in  1  from fpa sign.
- fpa_exp  in  8  from fpa exp.
- fpa_mantis  in  23  from fpa mantis.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  32  accumulated sum.
- out_count  out  CNT_W  number of elements in the sum (saturating).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=32'h0000_0000 (+0.0), count=0, out_valid=0, out_data=0, out_count=0.
- States:
  - IDLE: acc=+0, no element accepted yet.
  - ACC: at least one element accepted, no last yet.
  - HOLD: result presented.
- in_ready = 1 in IDLE and ACC, 0 in HOLD. Accept = in_valid & in_ready.
- On accept:
  - acc <= {fpa_sign, fpa_exp, fpa_mantis}, i.e. the fpa sum of old acc and in_data, computed combinationally in the same cycle.
  - count <= count+1, held at all-ones once reached.
  - Latency: one element per cycle, zero bubbles.
- Accept with in_last=0: IDLE->ACC (ACC stays ACC).
- Accept with in_last=1: ->HOLD. out_data <= fpa result, out_count <= count+1 (saturating), out_valid <= 1 on the next edge. Latency from last accept to out_valid is 1 cycle.
- HOLD:
  - out_data and out_count stable while out_valid=1 & out_ready=0.
  - in_data and in_valid are ignored.
  - On out_valid & out_ready: out_valid<=0, acc<=+0, count<=0, state->IDLE. in_ready rises the following cycle; no same-cycle pass-through.
- Arithmetic: no local float math. Rounding, overflow to infinity, and infinity/NaN propagation are exactly as `fpa` produces them; `fpa` results are captured bit-exact.
- Reset mid-operation: partial sum and count are discarded immediately; no output is produced for the aborted stream.
- fpa_a/fpa_b may change every cycle; only the value on the accept cycle is captured.

Optional Feature:
- Macro FPA_STREAM_ACC_NAN_STICKY_EN.
- Defined:
  - Adds a sticky nan_seen register, reset 0. It sets on accept when in_data or the fpa result is NaN (exp=8'hFF, mantis!=0).
  - While nan_seen=1, acc is held at the canonical NaN 32'h7FC0_0000, subsequent fpa results are ignored, and count still increments.
  - out_data = 32'h7FC0_0000 for that stream. nan_seen clears together with acc on output handshake.
- Undefined: no sticky logic; acc always takes the fpa result.

Test Plan:
- Stream 3F80_0000 (1.0), then 4000_0000 (2.0) with last; out_ready=1 -> out_valid one cycle after second accept, out_data=4040_0000 (3.0), out_count=2; next cycle in_ready=1, acc=0.
- Single element C120_0000 (-10.0) with last -> out_data=C120_0000, out_count=1 (0+x exact).
- After last, hold out_ready=0 for 3 cycles while driving in_valid=1 with 3F80_0000 -> in_ready=0 throughout, out_data/out_count unchanged. Release out_ready -> handshake; the held input is accepted only after IDLE is reached.
- CNT_W=4, twenty back-to-back 3F80_0000 elements with last on the 20th -> out_data=41A0_0000 (20.0), out_count=4'hF (saturated), in_ready=1 every cycle.
- Accept 4040_0000 and 3F80_0000 (no last), assert rst_n=0 asynchronously mid-cycle -> out_valid=0, acc=0, count=0 immediately. Then stream 3F80_0000 with last -> out_data=3F80_0000, out_count=1.
- With FPA_STREAM_ACC_NAN_STICKY_EN: stream 3F80_0000, 7FC0_0001, 4000_0000 (last) -> out_data=7FC0_0000, out_count=3. Without the macro, out_data equals whatever fpa returns for the NaN chain.
